// File: rtl/mul_div_unit_if.sv
// Request/result bundle between an issuing master and the mul_div_unit.
// Master drives operands and start; slave returns status and register-file writes.
// Handshake is start/busy/done; there is no backpressure on the result strobe.
interface mul_div_unit_if;
    logic        start;
    logic        op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [3:0]  dest;
    logic        busy;
    logic        done;
    logic [3:0]  writeaddress1;
    logic [3:0]  writeaddress2;
    logic [15:0] writedata1;
    logic [15:0] writedata2;
    logic        enable1;
    logic        enable2;
    logic        divzero;
    logic        ovf;

    modport master (
        output start, op, opa, opb, dest,
        input  busy, done, writeaddress1, writeaddress2, writedata1, writedata2,
               enable1, enable2, divzero, ovf
    );

    modport slave (
        input  start, op, opa, opb, dest,
        output busy, done, writeaddress1, writeaddress2, writedata1, writedata2,
               enable1, enable2, divzero, ovf
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative signed 16x16 multiply / 16/16 divide with register-file write-back.
// Latency: fixed, result strobe in the cycle after the 18th edge following acceptance.
// Backpressure: none; start is only sampled in IDLE, write-back cannot be stalled.
module mul_div_unit (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, WB} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt;
    logic        op_q, sa_q, sb_q, bzero_q, ovfcase_q;
    logic [3:0]  dest_q;
    logic [15:0] opa_q;
    logic [15:0] hi, lo, m;

    logic        busy_q, done_q, en1_q, en2_q, dz_q, ovf_q;
    logic [3:0]  wa1_q;
    logic [15:0] wd1_q, wd2_q;

    logic [15:0] a_mag, b_mag;
    logic [16:0] mul_sum;
    logic [16:0] div_sh;
    logic        div_ge;
    logic [15:0] div_sub;

    assign a_mag   = bus.opa[15] ? 16'(-bus.opa) : bus.opa;
    assign b_mag   = bus.opb[15] ? 16'(-bus.opb) : bus.opb;
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : 17'd0);
    assign div_sh  = {hi, lo[15]};
    assign div_ge  = div_sh >= {1'b0, m};
    // Remainder is always below the divisor, so the low 16 bits hold the full difference.
    assign div_sub = div_sh[15:0] - m;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (cnt == 4'd15) state_d = FIX;
            FIX:     state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt       <= 4'd0;
            op_q      <= 1'b0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            bzero_q   <= 1'b0;
            ovfcase_q <= 1'b0;
            dest_q    <= 4'd0;
            opa_q     <= 16'd0;
            hi        <= 16'd0;
            lo        <= 16'd0;
            m         <= 16'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            en1_q     <= 1'b1;
            en2_q     <= 1'b1;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            wa1_q     <= 4'd0;
            wd1_q     <= 16'd0;
            wd2_q     <= 16'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_q != IDLE) || bus.start;
            done_q  <= (state_q == WB);
            en1_q   <= (state_q != WB);
            en2_q   <= (state_q != WB);
            case (state_q)
                IDLE: if (bus.start) begin
                    op_q      <= bus.op;
                    dest_q    <= bus.dest;
                    opa_q     <= bus.opa;
                    sa_q      <= bus.opa[15];
                    sb_q      <= bus.opb[15];
                    bzero_q   <= (bus.opb == 16'd0);
                    ovfcase_q <= (bus.opa == 16'h8000) && (bus.opb == 16'hFFFF);
                    cnt       <= 4'd0;
                    hi        <= 16'd0;
                    // Multiply shifts the multiplier out of lo; divide shifts the dividend out.
                    lo        <= bus.op ? a_mag : b_mag;
                    m         <= bus.op ? b_mag : a_mag;
                end
                CALC: begin
                    cnt <= cnt + 4'd1;
                    if (!op_q) begin
                        hi <= mul_sum[16:1];
                        lo <= {mul_sum[0], lo[15:1]};
                    end else if (div_ge) begin
                        hi <= div_sub;
                        lo <= {lo[14:0], 1'b1};
                    end else begin
                        hi <= div_sh[15:0];
                        lo <= {lo[14:0], 1'b0};
                    end
                end
                FIX: begin
                    if (!op_q) begin
                        if (sa_q ^ sb_q) {hi, lo} <= -{hi, lo};
                    end else if (bzero_q) begin
                        lo <= 16'hFFFF;
                        hi <= opa_q;
                    end else begin
                        if (sa_q ^ sb_q) lo <= -lo;
                        if (sa_q)        hi <= -hi;
                    end
                end
                WB: begin
                    wa1_q <= dest_q;
                    wd1_q <= lo;
                    wd2_q <= hi;
                    dz_q  <= op_q && bzero_q;
                    ovf_q <= op_q && ovfcase_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.enable1       = en1_q;
    assign bus.enable2       = en2_q;
    assign bus.divzero       = dz_q;
    assign bus.ovf           = ovf_q;
    assign bus.writeaddress1 = wa1_q;
    assign bus.writeaddress2 = 4'hF;
    assign bus.writedata1    = wd1_q;
    assign bus.writedata2    = wd2_q;
endmodule
